// File: rtl/minc_prog_loader.sv
// Framed byte-stream loader for the minc 256 x 10-bit program memory.
// Packs (HI, LO) byte pairs into words, verifies an XOR checksum, and gates the core's reset.
module minc_prog_loader #(
  parameter int          ADDR_W = 8,
  parameter int          INSN_W = 10,
  parameter logic [7:0]  SYNC   = 8'hA5
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [INSN_W-1:0] mem_wdata,
  output logic              cpu_nreset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   loaded_len
);

  localparam int             HI_W = INSN_W - 8;
  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_HI, S_LO, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t            r_state;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_cnt;
  logic [HI_W-1:0]   r_hi;
  logic [7:0]        r_xor;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [INSN_W-1:0] r_wdata;
  logic              r_nrst;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [ADDR_W:0]   r_loaded_len;

  logic              w_accept;
  logic              w_hi_bad;
  logic [ADDR_W:0]   w_cnt_next;

  // Never back-pressures; ready simply tracks reset so nothing is taken while held.
  assign in_ready   = ~RESET;
  assign w_accept   = in_valid & ~RESET;
  assign w_hi_bad   = (in_data >> HI_W) != '0;
  assign w_cnt_next = r_cnt + 1'b1;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_cnt        <= '0;
      r_hi         <= '0;
      r_xor        <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_nrst       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_loaded_len <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_accept) begin
        unique case (r_state)
          S_IDLE, S_DONE, S_ERR: begin
            if (in_data == SYNC) begin
              r_state <= S_LEN;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
              r_err   <= 1'b0;
              r_nrst  <= 1'b0;
              r_cnt   <= '0;
              r_xor   <= '0;
            end
          end
          S_LEN: begin
            r_len   <= (in_data == '0) ? FULL : (ADDR_W+1)'(in_data);
            r_xor   <= r_xor ^ in_data;
            r_state <= S_HI;
          end
          S_HI: begin
            if (w_hi_bad) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_hi    <= in_data[HI_W-1:0];
              r_xor   <= r_xor ^ in_data;
              r_state <= S_LO;
            end
          end
          S_LO: begin
            r_xor        <= r_xor ^ in_data;
            r_we         <= 1'b1;
            r_addr       <= r_cnt[ADDR_W-1:0];
            r_wdata      <= {r_hi, in_data};
            r_cnt        <= w_cnt_next;
            r_loaded_len <= w_cnt_next;
            r_state      <= (w_cnt_next == r_len) ? S_CSUM : S_HI;
          end
          S_CSUM: begin
            r_busy <= 1'b0;
            if (in_data == r_xor) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_nrst  <= 1'b1;
            end else begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign mem_we     = r_we;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign cpu_nreset = r_nrst;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_err;
  assign loaded_len = r_loaded_len;

endmodule

// File: tb/tb_minc_prog_loader.sv
// Self-checking bench for minc_prog_loader: byte streams are parsed by a frame-level
// reference model and the DUT's write pulses, captured words and status are compared.
module tb_minc_prog_loader;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [9:0]  mem_wdata;
  logic        cpu_nreset;
  logic        busy;
  logic        done;
  logic        error;
  logic [8:0]  loaded_len;

  int errors = 0;
  int checks = 0;

  minc_prog_loader #(.ADDR_W(8), .INSN_W(10), .SYNC(8'hA5)) dut (
    .CLK(CLK), .RESET(RESET), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_nreset(cpu_nreset),
    .busy(busy), .done(done), .error(error), .loaded_len(loaded_len)
  );

  always #5 CLK = ~CLK;

  // Every write pulse seen by memory, as {addr, data}.
  logic [17:0] cap_q[$];
  always @(negedge CLK) if (mem_we === 1'b1) cap_q.push_back({mem_addr, mem_wdata});

  // Reference model state: frame-level parse of the whole byte stream.
  logic [7:0]  stim_q[$];
  bit          exp_we[$];
  logic [17:0] exp_wr[$];
  bit          m_done, m_err, m_nrst, m_busy;
  int          m_loaded;

  task automatic reset_model();
    m_done = 0; m_err = 0; m_nrst = 0; m_busy = 0; m_loaded = 0;
  endtask

  task automatic model_stream();
    int i, n, len;
    logic [7:0] x, hi, lo;
    bit aborted;
    n = stim_q.size();
    exp_we = {};
    exp_wr = {};
    for (int k = 0; k < n; k++) exp_we.push_back(1'b0);
    i = 0;
    while (i < n) begin
      if (stim_q[i] != 8'hA5) begin i++; continue; end
      m_done = 0; m_err = 0; m_nrst = 0; m_busy = 1;
      i++;
      if (i >= n) break;
      len = (stim_q[i] == 8'h00) ? 256 : int'(stim_q[i]);
      x = stim_q[i];
      i++;
      aborted = 0;
      for (int w = 0; w < len && !aborted && i < n; w++) begin
        hi = stim_q[i];
        i++;
        if (hi > 8'd3) begin
          aborted = 1; m_err = 1; m_busy = 0;
        end else if (i < n) begin
          lo = stim_q[i];
          x = x ^ hi ^ lo;
          exp_we[i] = 1'b1;
          exp_wr.push_back({w[7:0], hi[1:0], lo});
          m_loaded = w + 1;
          i++;
        end
      end
      if (aborted || i >= n) continue;
      if (stim_q[i] == x) begin m_done = 1; m_nrst = 1; end
      else m_err = 1;
      m_busy = 0;
      i++;
    end
  endtask

  // Drives stim_q (optionally with random idle gaps) and checks against the model.
  task automatic run_stream(input string name, input bit gaps);
    int g;
    model_stream();
    cap_q = {};
    for (int k = 0; k < stim_q.size(); k++) begin
      g = gaps ? int'($urandom_range(0, 2)) : 0;
      for (int j = 0; j < g; j++) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(negedge CLK);
        checks++;
        if (mem_we !== 1'b0) begin
          errors++;
          $display("FAIL %s gap_we byte=%0d got=%b want=0", name, k, mem_we);
        end
      end
      in_data  = stim_q[k];
      in_valid = 1'b1;
      @(negedge CLK);
      in_valid = 1'b0;
      checks++;
      if (mem_we !== exp_we[k]) begin
        errors++;
        $display("FAIL %s we_timing byte=%0d got=%b want=%b", name, k, mem_we, exp_we[k]);
      end
    end
    @(negedge CLK);
    checks++;
    if (cap_q.size() != exp_wr.size()) begin
      errors++;
      $display("FAIL %s write_count got=%0d want=%0d", name, cap_q.size(), exp_wr.size());
    end else begin
      for (int k = 0; k < exp_wr.size(); k++) begin
        checks++;
        if (cap_q[k] !== exp_wr[k]) begin
          errors++;
          $display("FAIL %s write[%0d] got addr=%h data=%h want addr=%h data=%h",
                   name, k, cap_q[k][17:10], cap_q[k][9:0], exp_wr[k][17:10], exp_wr[k][9:0]);
        end
      end
    end
    checks++;
    if ({done, error, cpu_nreset, busy} !== {m_done, m_err, m_nrst, m_busy}) begin
      errors++;
      $display("FAIL %s status got done/err/nrst/busy=%b%b%b%b want=%b%b%b%b", name,
               done, error, cpu_nreset, busy, m_done, m_err, m_nrst, m_busy);
    end
    checks++;
    if (loaded_len !== 9'(m_loaded)) begin
      errors++;
      $display("FAIL %s loaded_len got=%0d want=%0d", name, loaded_len, m_loaded);
    end
  endtask

  task automatic send_raw(input logic [7:0] b);
    in_data = b; in_valid = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      checks++;
      if ({in_ready, cpu_nreset, mem_we, busy, done, error} !== 6'b0 ||
          {mem_addr, mem_wdata, loaded_len} !== 27'd0) begin
        errors++;
        $display("FAIL reset_hold got rdy=%b nrst=%b we=%b busy=%b done=%b err=%b addr=%h data=%h len=%0d want all 0",
                 in_ready, cpu_nreset, mem_we, busy, done, error, mem_addr, mem_wdata, loaded_len);
      end
    end
    in_valid = 1'b0;
    RESET = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release in_ready got=%b want=1", in_ready);
    end
    @(negedge CLK);
    checks++;
    if ({busy, done, error, cpu_nreset} !== 4'b0) begin
      errors++;
      $display("FAIL reset_idle got busy/done/err/nrst=%b%b%b%b want=0000", busy, done, error, cpu_nreset);
    end
    reset_model();
  endtask

  task automatic test_good_frame();
    stim_q = '{8'h3C, 8'hA5, 8'h03, 8'h00, 8'h05, 8'h00, 8'h07, 8'h01, 8'h00, 8'h00};
    run_stream("good_frame", 1'b0);
    checks++;
    if (cap_q.size() != 3 || cap_q[0] !== {8'd0, 10'h005} || cap_q[1] !== {8'd1, 10'h007} ||
        cap_q[2] !== {8'd2, 10'h100}) begin
      errors++;
      $display("FAIL good_frame_words got n=%0d want 005,007,100 at 0..2", cap_q.size());
    end
  endtask

  task automatic test_bad_csum();
    stim_q = '{8'hA5, 8'h03, 8'h00, 8'h05, 8'h00, 8'h07, 8'h01, 8'h00, 8'h55};
    run_stream("bad_csum", 1'b0);
    stim_q = '{8'hA5, 8'h03, 8'h00, 8'h05, 8'h00, 8'h07, 8'h01, 8'h00, 8'h00};
    run_stream("after_bad_csum", 1'b0);
  endtask

  task automatic test_reserved_bits();
    stim_q = '{8'hA5, 8'h01, 8'h04, 8'h12, 8'h00};
    run_stream("reserved_bits", 1'b0);
  endtask

  task automatic test_full_memory();
    stim_q = '{8'hA5, 8'h00};
    for (int i = 0; i < 256; i++) begin
      stim_q.push_back(8'h00);
      stim_q.push_back(8'(i));
    end
    stim_q.push_back(8'h00);
    run_stream("full_memory", 1'b1);
  endtask

  task automatic test_random_frames();
    logic [7:0] x, hi, lo, len;
    for (int f = 0; f < 12; f++) begin
      stim_q = {};
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        x = 8'($urandom);
        stim_q.push_back((x == 8'hA5) ? 8'h5A : x);
      end
      len = 8'($urandom_range(1, 6));
      stim_q.push_back(8'hA5);
      stim_q.push_back(len);
      x = len;
      for (int w = 0; w < int'(len); w++) begin
        hi = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, 3));
        lo = 8'($urandom);
        x = x ^ hi ^ lo;
        stim_q.push_back(hi);
        stim_q.push_back(lo);
      end
      stim_q.push_back(($urandom_range(0, 3) == 0) ? ~x : x);
      run_stream("random_frame", 1'b1);
    end
  endtask

  task automatic test_reset_mid_load();
    send_raw(8'hA5); send_raw(8'h05);
    send_raw(8'h02); send_raw(8'h11);
    send_raw(8'h01); send_raw(8'h22);
    checks++;
    if ({mem_we, busy, mem_addr, mem_wdata} !== {1'b1, 1'b1, 8'd1, 10'h122}) begin
      errors++;
      $display("FAIL mid_load_write got we=%b busy=%b addr=%h data=%h want we=1 busy=1 addr=01 data=122",
               mem_we, busy, mem_addr, mem_wdata);
    end
    RESET = 1'b1;
    #1;
    checks++;
    if ({in_ready, mem_we, busy, done, error, cpu_nreset} !== 6'b0 ||
        {mem_addr, mem_wdata, loaded_len} !== 27'd0) begin
      errors++;
      $display("FAIL mid_reset got rdy=%b we=%b busy=%b addr=%h data=%h len=%0d want all 0",
               in_ready, mem_we, busy, mem_addr, mem_wdata, loaded_len);
    end
    @(negedge CLK); @(negedge CLK);
    RESET = 1'b0;
    reset_model();
    stim_q = '{8'hA5, 8'h02, 8'h03, 8'hA5, 8'h00, 8'h42, 8'hE4};
    run_stream("after_mid_reset", 1'b0);
  endtask

  initial begin
    RESET = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    reset_model();
    @(negedge CLK);
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_reserved_bits();
    test_full_memory();
    test_random_frames();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
